// File: rtl/xsoc_timer.sv
// xsoc_timer: 16-bit interval timer / PWM responder on the abstract control bus.
// Define XSOC_TIMER_PWM_EN to build in the COMPARE register (word 4) and pwm_out.
module xsoc_timer #(
  parameter int PRE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ctrl,
  input  logic        sel,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        ud_t,
  output logic        ld_t,
  output logic        irq,
  output logic        pwm_out
);

  logic             mem_ce, hit, unused_ctrl_bits;
  logic [2:0]       addr;
  logic             ud_ce_q, ld_ce_q, ud_t_q, ld_t_q;
  logic [15:0]      count_q, count_d, reload_q, reload_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             tc_q, tc_d, irq_q, pwm_q;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick, terminal, count_wr;

  assign mem_ce           = ctrl[7];
  assign hit              = sel & ctrl[6];
  assign addr             = ctrl[3:1];
  assign unused_ctrl_bits = ^{ctrl[15:12], ctrl[5:4], ctrl[0]};

  // Access strobes and lane enables, sampled once per accepted access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ud_ce_q <= 1'b0;
      ld_ce_q <= 1'b0;
      ud_t_q  <= 1'b1;
      ld_t_q  <= 1'b1;
    end else if (mem_ce) begin
      ud_ce_q <= hit & ctrl[9];
      ld_ce_q <= hit & ctrl[8];
      ud_t_q  <= ~(hit & ~ctrl[11]);
      ld_t_q  <= ~(hit & ~ctrl[10]);
    end
  end

  assign count_wr = (ld_ce_q | ud_ce_q) & (addr == 3'd0);
  assign tick     = ctl_q[0] & (ctl_q[3] ? (&presc_q) : 1'b1);
  assign terminal = tick & (count_q == 16'd0);

  // Next-state: bus writes take priority over counting and auto-clear
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    ctl_d    = ctl_q;
    tc_d     = tc_q;
    presc_d  = presc_q;
    if (count_wr) begin
      count_d[7:0]  = ld_ce_q ? din[7:0]  : count_q[7:0];
      count_d[15:8] = ud_ce_q ? din[15:8] : count_q[15:8];
    end else if (tick) begin
      if (count_q != 16'd0) count_d = count_q - 16'd1;
      else if (ctl_q[2])    count_d = 16'd0;
      else                  count_d = reload_q;
    end else begin
      count_d = count_q;
    end
    if (!ctl_q[0] || count_wr) presc_d = '0;
    else if (ctl_q[3])         presc_d = presc_q + {{(PRE_W-1){1'b0}}, 1'b1};
    else                       presc_d = presc_q;
    if (addr == 3'd1) begin
      reload_d[7:0]  = ld_ce_q ? din[7:0]  : reload_q[7:0];
      reload_d[15:8] = ud_ce_q ? din[15:8] : reload_q[15:8];
    end else begin
      reload_d = reload_q;
    end
    if (terminal && ctl_q[2]) ctl_d[0] = 1'b0;
    else                      ctl_d[0] = ctl_q[0];
    if (ld_ce_q && (addr == 3'd2)) ctl_d = din[3:0];
    else                           ctl_d = ctl_d;
    if (ld_ce_q && (addr == 3'd3) && din[0]) tc_d = 1'b0;
    else                                     tc_d = tc_q;
    if (terminal) tc_d = 1'b1;
    else          tc_d = tc_d;
  end

  // Timer state registers; irq is registered so it cannot glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 16'h0000;
      reload_q <= 16'hFFFF;
      ctl_q    <= 4'h0;
      tc_q     <= 1'b0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctl_q    <= ctl_d;
      tc_q     <= tc_d;
      presc_q  <= presc_d;
      irq_q    <= tc_d & ctl_d[1];
    end
  end

`ifdef XSOC_TIMER_PWM_EN
  logic [15:0] compare_q;

  // COMPARE register and registered PWM comparator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= 16'h0000;
      pwm_q     <= 1'b0;
    end else begin
      if (ld_ce_q && (addr == 3'd4)) compare_q[7:0]  <= din[7:0];
      if (ud_ce_q && (addr == 3'd4)) compare_q[15:8] <= din[15:8];
      pwm_q <= ctl_q[0] & (count_q < compare_q);
    end
  end
`else
  assign pwm_q = 1'b0;
`endif

  // Live read mux of the addressed register
  always_comb begin
    dout = 16'h0000;
    case (addr)
      3'd0:    dout = count_q;
      3'd1:    dout = reload_q;
      3'd2:    dout = {12'h000, ctl_q};
      3'd3:    dout = {15'h0000, tc_q};
`ifdef XSOC_TIMER_PWM_EN
      3'd4:    dout = compare_q;
`endif
      default: dout = 16'h0000;
    endcase
  end

  assign ud_t    = ud_t_q;
  assign ld_t    = ld_t_q;
  assign irq     = irq_q;
  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_xsoc_timer.sv
// Self-checking bench for xsoc_timer: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model of the register map and counter.
module tb_xsoc_timer;
  localparam int PRE_W   = 8;
  localparam int PRE_MAX = (1 << PRE_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl;
  logic        sel;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ud_t, ld_t, irq, pwm_out;
  int          n_checks = 0;
  int          n_pass   = 0;

  xsoc_timer #(.PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .sel(sel), .din(din),
    .dout(dout), .ud_t(ud_t), .ld_t(ld_t), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_count, m_reload, m_compare;
  int          m_presc;
  logic [3:0]  m_ctl;
  bit          m_tc, m_irq, m_pwm, m_ld_ce, m_ud_ce, m_ld_t, m_ud_t;

  function automatic logic [15:0] m_read(input int a);
    case (a)
      0: return m_count;
      1: return m_reload;
      2: return {12'h000, m_ctl};
      3: return {15'h0000, m_tc};
`ifdef XSOC_TIMER_PWM_EN
      4: return m_compare;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural model: one step per clock edge, bus write outranks counting
  always @(posedge clk or posedge rst) begin : model
    int a;
    bit lo, hi, tick, term, wr_cnt, ntc, h;
    logic [15:0] nc, nr, ncmp;
    logic [3:0] nctl;
    if (rst) begin
      m_count <= 16'h0000; m_reload <= 16'hFFFF; m_compare <= 16'h0000;
      m_presc <= 0; m_ctl <= 4'h0; m_tc <= 1'b0; m_irq <= 1'b0; m_pwm <= 1'b0;
      m_ld_ce <= 1'b0; m_ud_ce <= 1'b0; m_ld_t <= 1'b1; m_ud_t <= 1'b1;
    end else begin
      a = int'(ctrl[3:1]);
      lo = m_ld_ce; hi = m_ud_ce;
      tick = m_ctl[0] && (!m_ctl[3] || m_presc == PRE_MAX);
      term = tick && m_count == 16'h0000;
      wr_cnt = (lo || hi) && a == 0;
      nc = m_count;
      if (wr_cnt) nc = {hi ? din[15:8] : m_count[15:8], lo ? din[7:0] : m_count[7:0]};
      else if (tick) nc = (m_count != 16'h0000) ? m_count - 16'd1 : (m_ctl[2] ? 16'h0000 : m_reload);
      nr = m_reload;
      if (a == 1) nr = {hi ? din[15:8] : m_reload[15:8], lo ? din[7:0] : m_reload[7:0]};
      ncmp = m_compare;
`ifdef XSOC_TIMER_PWM_EN
      if (a == 4) ncmp = {hi ? din[15:8] : m_compare[15:8], lo ? din[7:0] : m_compare[7:0]};
      m_pwm <= m_ctl[0] && (m_count < m_compare);
`else
      m_pwm <= 1'b0;
`endif
      nctl = m_ctl;
      if (term && m_ctl[2]) nctl[0] = 1'b0;
      if (lo && a == 2) nctl = din[3:0];
      ntc = m_tc;
      if (lo && a == 3 && din[0]) ntc = 1'b0;
      if (term) ntc = 1'b1;
      m_presc <= (!m_ctl[0] || wr_cnt) ? 0 : (m_ctl[3] ? (m_presc + 1) % (PRE_MAX + 1) : m_presc);
      m_count <= nc; m_reload <= nr; m_compare <= ncmp; m_ctl <= nctl; m_tc <= ntc;
      m_irq <= ntc && nctl[1];
      if (ctrl[7]) begin
        h = sel && ctrl[6];
        m_ld_ce <= h && ctrl[8];
        m_ud_ce <= h && ctrl[9];
        m_ld_t  <= !(h && !ctrl[10]);
        m_ud_t  <= !(h && !ctrl[11]);
      end
    end
  end

  // One bus cycle: drive inputs just after a falling edge, return at the next one.
  task automatic drive(input logic s, input logic sio, input logic mce, input logic [3:0] nxt,
                       input logic [2:0] a, input logic [15:0] d);
    ctrl = {4'($urandom), nxt, mce, sio, 2'($urandom), a, 1'($urandom)};
    sel = s; din = d;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, input logic lo, input logic hi);
    drive(1'b1, 1'b1, 1'b1, {2'b11, hi, lo}, a, d);
    drive(1'b0, 1'b1, 1'b1, 4'b1111, a, d);
  endtask

  task automatic bus_read(input logic [2:0] a);
    drive(1'b1, 1'b1, 1'b1, 4'b0000, a, 16'h0000);
    ctrl[7] = 1'b0;
  endtask

  task automatic bus_close(input logic [2:0] a);
    drive(1'b0, 1'b1, 1'b1, 4'b1111, a, 16'h0000);
  endtask

  task automatic test_reset();
    logic [15:0] rexp [4];
    rexp[0] = 16'h0000; rexp[1] = 16'hFFFF; rexp[2] = 16'h0000; rexp[3] = 16'h0000;
    n_checks++; if ({irq, ud_t, ld_t, pwm_out} !== 4'b0110) $display("FAIL rst_outs: got %b want 0110", {irq, ud_t, ld_t, pwm_out}); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b0000, a[2:0], 16'h0000);
      n_checks++; if ({ud_t, ld_t} !== 2'b11) $display("FAIL rst_nosel%0d: lanes=%b want 11", a, {ud_t, ld_t}); else n_pass++;
      bus_read(a[2:0]);
      n_checks++; if ({ud_t, ld_t} !== 2'b00) $display("FAIL rst_lanes%0d: lanes=%b want 00", a, {ud_t, ld_t}); else n_pass++;
      n_checks++; if (dout !== rexp[a]) $display("FAIL rst_rd%0d: dout=%h want %h", a, dout, rexp[a]); else n_pass++;
      bus_close(a[2:0]);
      n_checks++; if ({ud_t, ld_t} !== 2'b11) $display("FAIL rst_close%0d: lanes=%b want 11", a, {ud_t, ld_t}); else n_pass++;
    end
  endtask

  task automatic test_periodic();
    int edges, rise;
    logic [15:0] seq [5];
    seq[0] = 16'd2; seq[1] = 16'd1; seq[2] = 16'd0; seq[3] = 16'd3; seq[4] = 16'd2;
    rise = -1;
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd3, 16'h0001, 1'b1, 1'b0);
    bus_write(3'd1, 16'h0003, 1'b1, 1'b1);
    bus_write(3'd0, 16'h0003, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0003, 1'b1, 1'b1);
    edges = 1;
    bus_read(3'd0);
    edges = 2;
    n_checks++; if (dout !== 16'd2) $display("FAIL per_first: dout=%h want 0002", dout); else n_pass++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); edges++;
      n_checks++; if (dout !== m_read(0)) $display("FAIL per_cnt: dout=%h want %h", dout, m_read(0)); else n_pass++;
      n_checks++; if (irq !== m_irq) $display("FAIL per_irq: irq=%b want %b", irq, m_irq); else n_pass++;
      if (edges <= 6) begin
        n_checks++; if (dout !== seq[edges-2]) $display("FAIL per_seq: dout=%h want %h", dout, seq[edges-2]); else n_pass++;
      end
      if (irq === 1'b1 && rise < 0) rise = edges;
    end
    n_checks++; if (rise !== 5) $display("FAIL per_rise: irq rose after %0d edges want 5", rise); else n_pass++;
    bus_write(3'd3, 16'h0001, 1'b1, 1'b0);
    n_checks++; if (irq !== 1'b0) $display("FAIL per_clr: irq=%b want 0", irq); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (irq !== 1'b0) $display("FAIL per_low: irq=%b want 0", irq); else n_pass++;
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) $display("FAIL per_again: irq=%b want 1", irq); else n_pass++;
  endtask

  task automatic test_oneshot();
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd3, 16'h0001, 1'b1, 1'b0);
    bus_write(3'd0, 16'h0002, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0005, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    bus_read(3'd2);
    n_checks++; if (dout !== 16'h0004) $display("FAIL os_ctrl: dout=%h want 0004", dout); else n_pass++;
    bus_close(3'd2);
    bus_read(3'd0);
    n_checks++; if (dout !== 16'h0000) $display("FAIL os_cnt: dout=%h want 0000", dout); else n_pass++;
    bus_close(3'd0);
    bus_read(3'd3);
    n_checks++; if (dout !== 16'h0001) $display("FAIL os_tc: dout=%h want 0001", dout); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL os_irq: irq=%b want 0", irq); else n_pass++;
    bus_close(3'd3);
  endtask

  task automatic test_prescale();
    int edges, first;
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd0, 16'h0001, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0009, 1'b1, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        repeat (100) @(negedge clk);
        bus_write(3'd0, 16'h0001, 1'b1, 1'b1);
      end
      first = -1;
      bus_read(3'd0);
      edges = 1;
      for (int i = 0; i < 300 && first < 0; i++) begin
        @(negedge clk); edges++;
        n_checks++; if (dout !== m_read(0)) $display("FAIL pre_cnt: dout=%h want %h", dout, m_read(0)); else n_pass++;
        if (dout === 16'h0000) first = edges;
      end
      n_checks++; if (first !== 256) $display("FAIL pre_first%0d: decrement after %0d clocks want 256", pass, first); else n_pass++;
    end
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_collisions();
    bus_write(3'd1, 16'hFFFF, 1'b1, 1'b1);
    bus_write(3'd0, 16'h1280, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0001, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    bus_write(3'd0, 16'h55AB, 1'b1, 1'b0);
    n_checks++; if (dout !== 16'h12AB) $display("FAIL col_lo: dout=%h want 12ab", dout); else n_pass++;
    bus_write(3'd0, 16'h3400, 1'b0, 1'b1);
    n_checks++; if (dout !== m_read(0) || dout[15:8] !== 8'h34) $display("FAIL col_hi: dout=%h want %h", dout, m_read(0)); else n_pass++;
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd1, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd0, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd3, 16'h0001, 1'b1, 1'b0);
    bus_write(3'd2, 16'h0001, 1'b1, 1'b1);
    bus_write(3'd3, 16'h0001, 1'b1, 1'b0);
    bus_read(3'd3);
    n_checks++; if (dout !== 16'h0001) $display("FAIL col_tc: dout=%h want 0001", dout); else n_pass++;
    bus_close(3'd3);
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 4'b1101, 3'd2, 16'h0005);
    drive(1'b1, 1'b1, 1'b0, 4'b1101, 3'd2, 16'h0005);
    drive(1'b1, 1'b1, 1'b0, 4'b1101, 3'd2, 16'h0005);
    drive(1'b0, 1'b1, 1'b1, 4'b1111, 3'd2, 16'h0005);
    n_checks++; if (dout !== 16'h0005) $display("FAIL col_en: dout=%h want 0005", dout); else n_pass++;
    @(negedge clk);
    n_checks++; if (dout !== 16'h0004) $display("FAIL col_os: dout=%h want 0004", dout); else n_pass++;
  endtask

  task automatic test_pwm();
    int highs;
    highs = 0;
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
`ifdef XSOC_TIMER_PWM_EN
    bus_write(3'd1, 16'd9, 1'b1, 1'b1);
    bus_write(3'd4, 16'd3, 1'b1, 1'b1);
    bus_write(3'd0, 16'd9, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0001, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (pwm_out !== m_pwm) $display("FAIL pwm_bit: pwm=%b want %b", pwm_out, m_pwm); else n_pass++;
      if (pwm_out === 1'b1) highs++;
    end
    n_checks++; if (highs !== 6) $display("FAIL pwm_duty: highs=%0d want 6", highs); else n_pass++;
`else
    bus_write(3'd4, 16'hBEEF, 1'b1, 1'b1);
    bus_read(3'd4);
    n_checks++; if (dout !== 16'h0000) $display("FAIL pwm_w4: dout=%h want 0000", dout); else n_pass++;
    bus_close(3'd4);
    bus_write(3'd1, 16'd9, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0001, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    n_checks++; if (highs !== 0) $display("FAIL pwm_off: highs=%0d want 0", highs); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [2:0]  a, ra;
    logic [15:0] d;
    logic        lo, hi, s, sio;
    for (int it = 0; it < 150; it++) begin
      a   = 3'($urandom_range(0, 7));
      lo  = 1'($urandom); hi = 1'($urandom);
      s   = ($urandom_range(0, 7) != 0);
      sio = ($urandom_range(0, 7) != 0);
      d   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      drive(s, sio, 1'b1, {2'b11, hi, lo}, a, d);
      drive(1'b0, 1'b1, 1'b1, 4'b1111, a, d);
      ra = 3'($urandom_range(0, 7));
      drive(1'b1, 1'b1, 1'b1, {2'($urandom), 2'b00}, ra, 16'h0000);
      ctrl[7] = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        @(negedge clk);
        n_checks++; if (dout !== m_read(int'(ra))) $display("FAIL rnd_dout: a=%0d dout=%h want %h", ra, dout, m_read(int'(ra))); else n_pass++;
        n_checks++; if ({irq, pwm_out} !== {m_irq, m_pwm}) $display("FAIL rnd_irqpwm: got %b want %b", {irq, pwm_out}, {m_irq, m_pwm}); else n_pass++;
        n_checks++; if ({ud_t, ld_t} !== {m_ud_t, m_ld_t}) $display("FAIL rnd_lanes: got %b want %b", {ud_t, ld_t}, {m_ud_t, m_ld_t}); else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    bus_write(3'd2, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd1, 16'h0005, 1'b1, 1'b1);
    bus_write(3'd0, 16'h0000, 1'b1, 1'b1);
    bus_write(3'd2, 16'h0003, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (irq !== 1'b1) $display("FAIL ar_pre: irq=%b want 1", irq); else n_pass++;
    bus_read(3'd1);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dout !== 16'hFFFF) $display("FAIL ar_dout: dout=%h want ffff", dout); else n_pass++;
    n_checks++; if ({irq, ud_t, ld_t, pwm_out} !== 4'b0110) $display("FAIL ar_outs: got %b want 0110", {irq, ud_t, ld_t, pwm_out}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctrl = 16'h0000; sel = 1'b0; din = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescale();
    test_collisions();
    test_pwm();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
